note_event_sequencer: RTL and testbench

//  Sequences the combinational frequency-to-note converter: accepts pitch estimates over a valid/ready

---
 rtl/note_event_sequencer.sv | 153 +++++++++++++++
 tb/tb_note_event_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/note_event_sequencer.sv
// note_event_sequencer
//   Feeds pitch estimates to an external combinational frequency-to-note
//   converter, debounces the returned 8-bit note code and reports committed
//   note changes as note-on / note-off events carrying the held duration.
//   Note code: [7:5] note, [4:3] accidental, [2:0] octave; 8'h00 is silence.
module note_event_sequencer #(
  parameter int unsigned STABLE_COUNT = 3,
  parameter int unsigned DUR_W        = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [15:0]      freq_in,
  input  logic             freq_valid_in,
  output logic             freq_ready_out,
  output logic [15:0]      conv_freq_out,
  input  logic [7:0]       conv_code_in,
  output logic             event_valid_out,
  input  logic             event_ready_in,
  output logic             event_on_out,
  output logic [7:0]       event_code_out,
  output logic [DUR_W-1:0] event_dur_out,
  output logic [7:0]       held_code_out
);

  localparam int unsigned      CNT_W   = $clog2(STABLE_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_COUNT);
  localparam logic [DUR_W-1:0] DUR_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_EVAL,
    S_EMIT_OFF,
    S_EMIT_ON
  } state_t;

  state_t           state_q;
  logic [15:0]      conv_freq_q;
  logic [7:0]       code_q;
  logic [7:0]       cand_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DUR_W-1:0] dur_q;
  logic [7:0]       held_q;
  logic             ev_valid_q;
  logic             ev_on_q;
  logic [7:0]       ev_code_q;
  logic [DUR_W-1:0] ev_dur_q;

  logic [CNT_W-1:0] cnt_d;
  logic [DUR_W-1:0] dur_d;
  logic             commit_d;

  // Post-update debounce count, saturating duration and commit decision for EVAL
  always_comb begin
    cnt_d    = CNT_W'(1);
    dur_d    = dur_q;
    commit_d = 1'b0;
    if (code_q == cand_q) begin
      cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
    end
    if (held_q != 8'h00 && dur_q != DUR_MAX) begin
      dur_d = dur_q + 1'b1;
    end
    // The candidate after EVAL is always code_q, so compare code_q with held
    commit_d = (cnt_d == CNT_MAX) && (code_q != held_q);
  end

  // Sequencing FSM with registered converter drive, debounce state and event outputs
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      conv_freq_q <= '0;
      code_q      <= '0;
      cand_q      <= '0;
      cnt_q       <= '0;
      dur_q       <= '0;
      held_q      <= '0;
      ev_valid_q  <= 1'b0;
      ev_on_q     <= 1'b0;
      ev_code_q   <= '0;
      ev_dur_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (freq_valid_in) begin
            conv_freq_q <= freq_in;
            state_q     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          code_q  <= conv_code_in;
          state_q <= S_EVAL;
        end
        S_EVAL: begin
          cand_q <= code_q;
          cnt_q  <= cnt_d;
          dur_q  <= dur_d;
          if (commit_d) begin
            ev_valid_q <= 1'b1;
            if (held_q != 8'h00) begin
              ev_on_q   <= 1'b0;
              ev_code_q <= held_q;
              ev_dur_q  <= dur_d;
              state_q   <= S_EMIT_OFF;
            end else begin
              // held is silence, so a commit implies a non-silent candidate
              ev_on_q   <= 1'b1;
              ev_code_q <= code_q;
              ev_dur_q  <= '0;
              state_q   <= S_EMIT_ON;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_EMIT_OFF: begin
          if (event_ready_in) begin
            if (cand_q != 8'h00) begin
              ev_on_q   <= 1'b1;
              ev_code_q <= cand_q;
              ev_dur_q  <= '0;
              state_q   <= S_EMIT_ON;
            end else begin
              ev_valid_q <= 1'b0;
              held_q     <= '0;
              state_q    <= S_IDLE;
            end
          end
        end
        S_EMIT_ON: begin
          if (event_ready_in) begin
            ev_valid_q <= 1'b0;
            held_q     <= cand_q;
            dur_q      <= '0;
            state_q    <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign freq_ready_out  = (state_q == S_IDLE) && !rst_in;
  assign conv_freq_out   = conv_freq_q;
  assign event_valid_out = ev_valid_q;
  assign event_on_out    = ev_on_q;
  assign event_code_out  = ev_code_q;
  assign event_dur_out   = ev_dur_q;
  assign held_code_out   = held_q;

endmodule

// File: tb/tb_note_event_sequencer.sv
// tb_note_event_sequencer
//   Directed scenarios plus a randomized sample stream; expected events come
//   from a per-sample model of the debounce/commit rules.
module tb_note_event_sequencer;

  localparam int unsigned SC      = 3;
  localparam int unsigned DW      = 4;
  localparam int          DUR_MAX = (1 << DW) - 1;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic [15:0]   freq_in = '0;
  logic          freq_valid_in = 1'b0;
  logic          freq_ready_out;
  logic [15:0]   conv_freq_out;
  logic [7:0]    conv_code_in;
  logic          event_valid_out;
  logic          event_ready_in = 1'b0;
  logic          event_on_out;
  logic [7:0]    event_code_out;
  logic [DW-1:0] event_dur_out;
  logic [7:0]    held_code_out;

  always #5 clk_in = ~clk_in;

  note_event_sequencer #(
    .STABLE_COUNT(SC),
    .DUR_W       (DW)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .freq_in        (freq_in),
    .freq_valid_in  (freq_valid_in),
    .freq_ready_out (freq_ready_out),
    .conv_freq_out  (conv_freq_out),
    .conv_code_in   (conv_code_in),
    .event_valid_out(event_valid_out),
    .event_ready_in (event_ready_in),
    .event_on_out   (event_on_out),
    .event_code_out (event_code_out),
    .event_dur_out  (event_dur_out),
    .held_code_out  (held_code_out)
  );

  // Converter stand-in: a few exact pitches, everything else out of range
  function automatic logic [7:0] note_of(input logic [15:0] f);
    case (f)
      16'd262: return 8'h4C;
      16'd330: return 8'h8C;
      16'd392: return 8'hCC;
      16'd440: return 8'h0C;
      16'd494: return 8'h2C;
      16'd523: return 8'h4D;
      default: return 8'h00;
    endcase
  endfunction

  assign conv_code_in = note_of(conv_freq_out);

  typedef struct {
    bit on;
    int code;
    int dur;
  } ev_t;

  ev_t exp_q[$];
  int  m_cand, m_cnt, m_held, m_dur;
  int  errors = 0;
  int  checks = 0;
  int  bp_fix = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_cand = 0; m_cnt = 0; m_held = 0; m_dur = 0;
    exp_q.delete();
  endfunction

  // One accepted sample: debounce, count held duration, queue any events
  function automatic void model_step(input int c);
    if (c == m_cand) m_cnt = (m_cnt < SC) ? m_cnt + 1 : SC;
    else begin m_cand = c; m_cnt = 1; end
    if (m_held != 0 && m_dur < DUR_MAX) m_dur++;
    if (m_cnt == SC && m_cand != m_held) begin
      if (m_held != 0) exp_q.push_back('{on: 1'b0, code: m_held, dur: m_dur});
      if (m_cand != 0) begin
        exp_q.push_back('{on: 1'b1, code: m_cand, dur: 0});
        m_held = m_cand;
        m_dur  = 0;
      end else begin
        m_held = 0;
      end
    end
  endfunction

  function automatic int pick_bp();
    return (bp_fix >= 0) ? bp_fix : int'($urandom_range(0, 2));
  endfunction

  task automatic do_reset();
    @(negedge clk_in);
    #2 rst_in = 1'b1;
    #1;
    check("rst_event_valid", event_valid_out, 0);
    check("rst_held", held_code_out, 0);
    check("rst_ready", freq_ready_out, 0);
    check("rst_conv_freq", conv_freq_out, 0);
    @(negedge clk_in);
    rst_in = 1'b0;
    freq_valid_in = 1'b0;
    event_ready_in = 1'b0;
    #1;
    check("ready_after_reset", freq_ready_out, 1);
    model_reset();
  endtask

  // Consume events (with backpressure) until the block is idle again
  task automatic drain();
    int n = 0;
    int bp;
    bit done = 0;
    bit acc_prev = 0;
    bp = pick_bp();
    while (!done && n < 200) begin
      @(negedge clk_in);
      n++;
      event_ready_in = 1'b0;
      if (acc_prev && exp_q.size() == 0) check("idle_after_accept", freq_ready_out, 1);
      acc_prev = 0;
      if (freq_ready_out && !event_valid_out) begin
        done = 1;
      end else if (event_valid_out) begin
        check("ready_low_in_event", freq_ready_out, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_event", event_valid_out, 0);
          event_ready_in = 1'b1;
        end else begin
          check("event_on", event_on_out, exp_q[0].on);
          check("event_code", event_code_out, exp_q[0].code);
          check("event_dur", event_dur_out, exp_q[0].dur);
          if (bp > 0) bp--;
          else begin
            event_ready_in = 1'b1;
            void'(exp_q.pop_front());
            acc_prev = 1;
            bp = pick_bp();
          end
        end
      end
    end
    check("drain_done", done, 1);
    check("missing_events", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic send(input int f, input bit do_drain);
    int n = 0;
    @(negedge clk_in);
    while (!freq_ready_out && n < 50) begin
      @(negedge clk_in);
      n++;
    end
    check("accept_ready", freq_ready_out, 1);
    freq_in = 16'(f);
    freq_valid_in = 1'b1;
    @(posedge clk_in);
    #1 freq_valid_in = 1'b0;
    check("conv_freq", conv_freq_out, f);
    model_step(int'(note_of(16'(f))));
    if (do_drain) drain();
  endtask

  int freqs[7] = '{100, 262, 330, 392, 440, 494, 523};

  initial begin
    int f;
    int n;

    // Power-on reset
    do_reset();

    // Onset: A4 stable three times
    repeat (3) send(440, 1);
    check("held_onset", held_code_out, 8'h0C);

    // Glitch shorter than the debounce window
    send(494, 1); send(440, 1); send(440, 1);
    check("held_glitch", held_code_out, 8'h0C);

    // Note change A4 -> C5
    do_reset();
    repeat (3) send(440, 1);
    repeat (3) send(523, 1);
    check("held_change", held_code_out, 8'h4D);

    // Note to silence
    do_reset();
    repeat (3) send(440, 1);
    repeat (3) send(100, 1);
    check("held_silence", held_code_out, 8'h00);

    // Backpressure on the onset event
    do_reset();
    bp_fix = 10;
    repeat (3) send(440, 1);
    bp_fix = -1;
    check("held_bp", held_code_out, 8'h0C);

    // Duration saturates rather than wrapping
    do_reset();
    repeat (3) send(440, 1);
    repeat (20) send(440, 1);
    repeat (3) send(523, 1);
    check("held_sat", held_code_out, 8'h4D);

    // Randomized stream with sticky pitches
    do_reset();
    f = 440;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) < 3) f = freqs[$urandom_range(0, 6)];
      send(f, 1);
      check("held_rand", held_code_out, m_held);
    end

    // Reset while a note-on event is pending
    do_reset();
    send(440, 1); send(440, 1); send(440, 0);
    n = 0;
    @(negedge clk_in);
    while (!event_valid_out && n < 20) begin
      @(negedge clk_in);
      n++;
    end
    check("onset_pending", event_valid_out, 1);
    check("onset_pending_on", event_on_out, 1);
    do_reset();
    check("held_after_midreset", held_code_out, 0);
    repeat (4) @(negedge clk_in);
    check("no_event_after_reset", event_valid_out, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
